// File: rtl/prim_assembler_pkg.sv
// gpu_pkg: shared types and constants for the primitive assembler.
//   prim_asm_state_t          : assembler FSM state encoding
//   FRAME_START_W/FRAME_END_W : default frame marker words
package gpu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        END_CHK = 2'd2
    } prim_asm_state_t;

    localparam logic [31:0] FRAME_START_W = 32'd0;
    localparam logic [31:0] FRAME_END_W   = 32'd1;

endpackage

// File: rtl/prim_assembler_if.sv
// prim_assembler_if: word stream in, primitive stream out.
//   in_data/in_valid/in_read    : read-buffer side, word moves on in_valid && in_read
//   out_data/out_valid/out_ready: rasteriser side, primitive moves on out_valid && out_ready
//   master modport: the environment; slave modport: the assembler
interface prim_assembler_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned WORDS  = 6
) ();

    logic [DATA_W-1:0]       in_data;
    logic                    in_valid;
    logic                    in_read;
    logic [WORDS*DATA_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_read, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_read, out_data, out_valid
    );

endinterface

// File: rtl/prim_assembler_out_buf.sv
// prim_out_buf: output holding register with valid/ready handshake.
//   clk, n_rst : clock, async active-low reset
//   i_load     : capture i_data and raise o_valid (only issued while o_valid=0)
//   i_data     : value to capture
//   i_ready    : downstream accepts; o_valid drops on the transfer edge
//   o_data     : held value
//   o_valid    : o_data holds an unconsumed value
module prim_out_buf #(
    parameter int unsigned W = 192
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid
);

    logic [W-1:0] r_data;
    logic         r_valid;

    // Load and drain never coincide: load is only issued while r_valid=0.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/prim_assembler.sv
// prim_assembler: gathers WORDS bus words between FRAME_START/FRAME_END markers
// into one primitive, double-buffered against the rasteriser.
//   clk, n_rst   : clock, async active-low reset
//   bus (slave)  : word input handshake and primitive output handshake
//   frame_active : between a start marker and an end marker
//   marker_err   : one-cycle pulse when a non-start word is discarded in IDLE
//   prim_count   : primitives emitted in the current frame
// Build option: define PRIM_ASM_COUNT_EN to build the prim_count counter;
// otherwise prim_count is tied to 0.
module prim_assembler
    import gpu_pkg::*;
#(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       WORDS       = 6,
    parameter logic [DATA_W-1:0] FRAME_START = DATA_W'(FRAME_START_W),
    parameter logic [DATA_W-1:0] FRAME_END   = DATA_W'(FRAME_END_W),
    parameter int unsigned       CNT_W       = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    prim_assembler_if.slave   bus,
    output logic              frame_active,
    output logic              marker_err,
    output logic [CNT_W-1:0]  prim_count
);

    localparam int unsigned IDX_W    = (WORDS > 2) ? $clog2(WORDS) : 1;
    localparam int unsigned PRIM_W   = WORDS * DATA_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    prim_asm_state_t   r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_slots [WORDS-1];
    logic              r_marker_err;

    logic              w_in_read;
    logic              w_xfer;
    logic              w_last;
    logic              w_load;
    logic              w_start;
    logic [PRIM_W-1:0] w_prim;
    logic [PRIM_W-1:0] w_out_data;
    logic              w_out_valid;

    // Stall on the last word while the previous primitive is still held.
    assign w_last    = (r_state == COLLECT) && (r_idx == LAST_IDX);
    assign w_in_read = !(w_last && w_out_valid);
    assign w_xfer    = bus.in_valid && w_in_read;
    assign w_load    = w_last && w_xfer;
    assign w_start   = (r_state == IDLE) && w_xfer && (bus.in_data == FRAME_START);

    // Completed primitive: stored slots plus the word being consumed now.
    always_comb begin
        w_prim = '0;
        for (int k = 0; k < WORDS - 1; k++) begin
            w_prim[k*DATA_W +: DATA_W] = r_slots[k];
        end
        w_prim[(WORDS-1)*DATA_W +: DATA_W] = bus.in_data;
    end

    // Frame FSM, collect buffer and slot index.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_marker_err <= 1'b0;
            for (int k = 0; k < WORDS - 1; k++) begin
                r_slots[k] <= '0;
            end
        end else begin
            r_marker_err <= 1'b0;
            if (w_xfer) begin
                case (r_state)
                    IDLE: begin
                        if (bus.in_data == FRAME_START) begin
                            r_state <= COLLECT;
                            r_idx   <= '0;
                        end else begin
                            r_marker_err <= 1'b1;
                        end
                    end
                    COLLECT: begin
                        // Data words are never inspected for marker values.
                        if (r_idx == LAST_IDX) begin
                            r_state <= END_CHK;
                            r_idx   <= '0;
                        end else begin
                            r_slots[r_idx] <= bus.in_data;
                            r_idx          <= r_idx + IDX_W'(1);
                        end
                    end
                    END_CHK: begin
                        if (bus.in_data == FRAME_END) begin
                            r_state <= IDLE;
                        end else begin
                            r_slots[0] <= bus.in_data;
                            r_idx      <= IDX_W'(1);
                            r_state    <= COLLECT;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    prim_out_buf #(
        .W (PRIM_W)
    ) u_out_buf (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_load  (w_load),
        .i_data  (w_prim),
        .i_ready (bus.out_ready),
        .o_data  (w_out_data),
        .o_valid (w_out_valid)
    );

`ifdef PRIM_ASM_COUNT_EN
    logic [CNT_W-1:0] r_prim_count;

    // Cleared on frame open, bumped on each load, wraps naturally.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_prim_count <= '0;
        end else if (w_start) begin
            r_prim_count <= '0;
        end else if (w_load) begin
            r_prim_count <= r_prim_count + CNT_W'(1);
        end
    end

    assign prim_count = r_prim_count;
`else
    assign prim_count = '0;
`endif

    assign bus.in_read   = w_in_read;
    assign bus.out_data  = w_out_data;
    assign bus.out_valid = w_out_valid;
    assign frame_active  = (r_state != IDLE);
    assign marker_err    = r_marker_err;

endmodule

// File: tb/tb_prim_assembler.sv
// Bench for prim_assembler (WORDS=6, DATA_W=32): vector table for marker
// handling plus directed sequences, with a queue scoreboard on the output side.
module tb_prim_assembler;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned WORDS  = 6;
    localparam int unsigned PW     = DATA_W * WORDS;

    logic        clk;
    logic        n_rst;
    logic        frame_active;
    logic        marker_err;
    logic [15:0] prim_count;

    int total = 0;
    int bad   = 0;
    int recv  = 0;
    int sent  = 0;

    logic [PW-1:0] exp_q[$];

    prim_assembler_if #(.DATA_W(DATA_W), .WORDS(WORDS)) bus ();

    prim_assembler #(
        .DATA_W (DATA_W),
        .WORDS  (WORDS)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .bus          (bus),
        .frame_active (frame_active),
        .marker_err   (marker_err),
        .prim_count   (prim_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_cnt(input int n);
`ifdef PRIM_ASM_COUNT_EN
        return 16'(n);
`else
        return 16'(n * 0);
`endif
    endfunction

    function automatic logic [PW-1:0] mk6(input logic [31:0] base);
        logic [PW-1:0] p;
        for (int k = 0; k < WORDS; k++) p[k*DATA_W +: DATA_W] = base + 32'(k);
        return p;
    endfunction

    // Scoreboard: every transfer seen mid-cycle is matched against the queue.
    always @(negedge clk) begin
        if (n_rst && bus.out_valid && bus.out_ready) begin
            recv++;
            if (exp_q.size() == 0) begin
                chk("unexpected_prim", bus.out_data, '0);
            end else begin
                chk("prim_data", bus.out_data, exp_q.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one word and hold it until the block reads it (bounded).
    task automatic push(input logic [31:0] w);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        forever begin
            @(negedge clk);
            if (bus.in_read) break;
            n++;
            if (n > 50) begin
                chk("push_timeout", 1'b1, 1'b0);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic push_run(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) push(base + 32'(i));
    endtask

    typedef struct {
        logic        v;
        logic [31:0] w;
        logic        err;
        logic        act;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1'b1, 32'h7, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 32'h0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 32'h9, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 32'h0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 32'h1, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 32'h2, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 32'h1, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 32'h1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 32'h0, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 32'h1, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 32'h5, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 32'h1, 1'b0, 1'b0};

        n_rst         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_marker_err", marker_err, 1'b0);
        chk("rst_prim_count", prim_count, '0);
        chk("rst_in_read", bus.in_read, 1'b1);
        chk("rst_frame_active", frame_active, 1'b0);
        n_rst = 1'b1;
        idle(2);

        // Single primitive
        exp_q.push_back(mk6(32'hA0)); sent++;
        push(32'h0);
        push_run(32'hA0, 6);
        push(32'h1);
        idle(3);
        chk("single_recv", 32'(recv), 32'(sent));
        chk("single_count", prim_count, exp_cnt(1));
        chk("single_idle", frame_active, 1'b0);

        // Back-to-back
        exp_q.push_back(mk6(32'hB0)); sent++;
        exp_q.push_back(mk6(32'hB6)); sent++;
        push(32'h0);
        push_run(32'hB0, 12);
        push(32'h1);
        idle(3);
        chk("b2b_recv", 32'(recv), 32'(sent));
        chk("b2b_count", prim_count, exp_cnt(2));

        // Marker handling table; data words equal to markers are stored
        exp_q.push_back({32'h5, 32'h1, 32'h0, 32'h1, 32'h2, 32'h1}); sent++;
        for (int i = 0; i < 12; i++) begin
            bus.in_valid = tbl[i].v;
            bus.in_data  = tbl[i].w;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_err", i), marker_err, tbl[i].err);
            chk($sformatf("tbl%0d_active", i), frame_active, tbl[i].act);
        end
        idle(3);
        chk("tbl_recv", 32'(recv), 32'(sent));

        // Back-pressure
        bus.out_ready = 1'b0;
        exp_q.push_back(mk6(32'hC0)); sent++;
        exp_q.push_back(mk6(32'hC6)); sent++;
        push(32'h0);
        push_run(32'hC0, 6);
        push_run(32'hC6, 5);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hCB;
        @(negedge clk);
        chk("bp_stall0", bus.in_read, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_stall1", bus.in_read, 1'b0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_drain_cycle", bus.in_read, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_resume", bus.in_read, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        push(32'h1);
        idle(3);
        chk("bp_recv", 32'(recv), 32'(sent));
        chk("bp_count", prim_count, exp_cnt(2));

        // Gapped input
        exp_q.push_back(mk6(32'hD0)); sent++;
        exp_q.push_back(mk6(32'hD6)); sent++;
        push(32'h0);
        for (int i = 0; i < 12; i++) begin
            idle($urandom_range(3, 0));
            push(32'hD0 + 32'(i));
        end
        push(32'h1);
        idle(3);
        chk("gap_recv", 32'(recv), 32'(sent));

        // Reset mid-primitive with a held, undrained output
        bus.out_ready = 1'b0;
        push(32'h0);
        push_run(32'hE0, 9);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 1'b0);
        chk("mid_rst_out_data", bus.out_data, '0);
        chk("mid_rst_count", prim_count, '0);
        chk("mid_rst_active", frame_active, 1'b0);
        chk("mid_rst_in_read", bus.in_read, 1'b1);
        chk("mid_rst_err", marker_err, 1'b0);
        idle(2);
        n_rst = 1'b1;
        bus.out_ready = 1'b1;
        idle(2);
        chk("post_rst_recv", 32'(recv), 32'(sent));

        // Recovery after reset
        exp_q.push_back(mk6(32'hF0)); sent++;
        push(32'h0);
        push_run(32'hF0, 6);
        push(32'h1);
        idle(3);
        chk("recover_recv", 32'(recv), 32'(sent));
        chk("recover_count", prim_count, exp_cnt(1));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
